// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable simple dual-port RAM.
// Holds the clear FSM state type, collision modes and the lane-count helper.
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int RD_OLD = 0;
    localparam int RD_NEW = 1;

    function automatic int lanes_f(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// Port bundle for ram_sdp_be: clear request, write port, read port, status.
// master drives requests and addresses; slave (the RAM) returns data and status.
interface ram_sdp_be_if
    import ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 4
);

    localparam int LANES = lanes_f(DATA_W, LANE_W);

    logic              Clr;
    logic              Busy;
    logic              We;
    logic [LANES-1:0]  Be;
    logic [ADDR_W-1:0] Wa;
    logic [DATA_W-1:0] Din;
    logic              Re;
    logic [ADDR_W-1:0] Ra;
    logic [DATA_W-1:0] Dout;
    logic              Dvalid;
    logic              Rej;

    modport master (
        output Clr, We, Be, Wa, Din, Re, Ra,
        input  Busy, Dout, Dvalid, Rej
    );

    modport slave (
        input  Clr, We, Be, Wa, Din, Re, Ra,
        output Busy, Dout, Dvalid, Rej
    );

endinterface

// File: rtl/ram_clr_fsm.sv
// Clear sweep controller: walks every address once after reset or Clr.
// Ports: Clk, Rst_n, Clr in; Busy, clr_addr, clr_we out.
module ram_clr_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clr,
    output logic              Busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t          state;
    logic [ADDR_W:0] cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (Clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign Busy     = (state == CLEAR);
    assign clr_we   = Busy;
    assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with per-lane byte enables, registered read and clear engine.
// Ports: Clk, Rst_n plain; all request/response signals via ram_sdp_be_if.slave.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int              DATA_W  = 16,
    parameter int              LANE_W  = 8,
    parameter int              ADDR_W  = 4,
    parameter int              RD_MODE = RD_OLD,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input logic         Clk,
    input logic         Rst_n,
    ram_sdp_be_if.slave bus
);

    localparam int LANES = lanes_f(DATA_W, LANE_W);
    localparam int DEPTH = 1 << ADDR_W;

    if (DATA_W % LANE_W != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of LANE_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;

    ram_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Clr      (bus.Clr),
        .Busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign bus.Busy = busy;

    // Clr wins over a same-cycle access, so it also blocks acceptance.
    logic accept;
    logic wr_en;
    logic rd_en;
    logic rej_d;

    assign accept = !busy && !bus.Clr;
    assign wr_en  = accept && bus.We;
    assign rd_en  = accept && bus.Re;
    assign rej_d  = (bus.We || bus.Re) && !accept;

    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;
    logic              collide;

    assign old_word = mem[bus.Ra];
    assign collide  = wr_en && (bus.Wa == bus.Ra);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (bus.Be[i]) begin
                merged[i*LANE_W +: LANE_W] = bus.Din[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_word = (RD_MODE == RD_NEW && collide) ? merged : old_word;

    // Storage has no reset; the sweep initialises it after every reset.
    always_ff @(posedge Clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.Be[i]) begin
                    mem[bus.Wa][i*LANE_W +: LANE_W] <=
                        bus.Din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.Dout   <= '0;
            bus.Dvalid <= 1'b0;
            bus.Rej    <= 1'b0;
        end else begin
            bus.Dvalid <= rd_en;
            bus.Rej    <= rej_d;
            if (rd_en) begin
                bus.Dout <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Self-checking bench for ram_sdp_be: one read-old and one write-through instance.
// A reference model predicts outputs; read results go through per-instance queues.
module tb_ram_sdp_be;

    logic Clk;
    logic Rst_n;

    ram_sdp_be_if #(.DATA_W(16), .LANE_W(8), .ADDR_W(4)) b0 ();
    ram_sdp_be_if #(.DATA_W(16), .LANE_W(8), .ADDR_W(4)) b1 ();

    ram_sdp_be #(.DATA_W(16), .LANE_W(8), .ADDR_W(4), .RD_MODE(0), .CLR_VAL(16'h0000))
        u0 (.Clk(Clk), .Rst_n(Rst_n), .bus(b0));
    ram_sdp_be #(.DATA_W(16), .LANE_W(8), .ADDR_W(4), .RD_MODE(1), .CLR_VAL(16'h0000))
        u1 (.Clk(Clk), .Rst_n(Rst_n), .bus(b1));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [15:0] mm [16];
    logic        m_busy;
    int          m_cnt;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] hold [2];
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic we, input logic [1:0] be,
                         input logic [3:0] wa, input logic [15:0] din,
                         input logic re, input logic [3:0] ra);
        b0.Clr = clr; b0.We = we; b0.Be = be; b0.Wa = wa;
        b0.Din = din; b0.Re = re; b0.Ra = ra;
        b1.Clr = clr; b1.We = we; b1.Be = be; b1.Wa = wa;
        b1.Din = din; b1.Re = re; b1.Ra = ra;
    endtask

    task automatic check_one(input int k, input logic busy, input logic rej,
                             input logic dv, input logic [15:0] dout,
                             input logic exp_rej, input logic exp_v);
        chk($sformatf("u%0d_busy", k), 32'(busy), 32'(m_busy));
        chk($sformatf("u%0d_rej", k), 32'(rej), 32'(exp_rej));
        chk($sformatf("u%0d_dvalid", k), 32'(dv), 32'(exp_v));
        if (dv === 1'b1) begin
            if (k == 0) begin
                if (q0.size() == 0) chk("u0_q_empty", 32'd1, 32'd0);
                else hold[0] = q0.pop_front();
            end else begin
                if (q1.size() == 0) chk("u1_q_empty", 32'd1, 32'd0);
                else hold[1] = q1.pop_front();
            end
        end
        chk($sformatf("u%0d_dout", k), 32'(dout), 32'(hold[k]));
    endtask

    task automatic step(input logic clr, input logic we, input logic [1:0] be,
                        input logic [3:0] wa, input logic [15:0] din,
                        input logic re, input logic [3:0] ra);
        logic        acc;
        logic        exp_rej;
        logic        exp_v;
        logic [15:0] old;
        logic [15:0] mrg;
        drive(clr, we, be, wa, din, re, ra);
        acc     = !m_busy && !clr;
        exp_rej = (we || re) && !acc;
        exp_v   = acc && re;
        old = mm[ra];
        mrg = old;
        if (be[0]) mrg[7:0]  = din[7:0];
        if (be[1]) mrg[15:8] = din[15:8];
        if (exp_v) begin
            q0.push_back(old);
            q1.push_back((we && wa == ra) ? mrg : old);
        end
        if (m_busy) begin
            mm[m_cnt] = 16'h0000;
            if (m_cnt == 15) m_busy = 1'b0;
            m_cnt++;
        end else if (clr) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (we) begin
            if (be[0]) mm[wa][7:0]  = din[7:0];
            if (be[1]) mm[wa][15:8] = din[15:8];
        end
        @(posedge Clk);
        #1;
        check_one(0, b0.Busy, b0.Rej, b0.Dvalid, b0.Dout, exp_rej, exp_v);
        check_one(1, b1.Busy, b1.Rej, b1.Dvalid, b1.Dout, exp_rej, exp_v);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        step(1'b0, 1'b1, be, a, d, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, a);
    endtask

    task automatic reset_check();
        chk("rst_dout0", 32'(b0.Dout), 32'h0);
        chk("rst_dout1", 32'(b1.Dout), 32'h0);
        chk("rst_busy0", 32'(b0.Busy), 32'h1);
        chk("rst_busy1", 32'(b1.Busy), 32'h1);
        chk("rst_dvalid0", 32'(b0.Dvalid), 32'h0);
        chk("rst_rej0", 32'(b0.Rej), 32'h0);
        m_busy  = 1'b1;
        m_cnt   = 0;
        hold[0] = 16'h0000;
        hold[1] = 16'h0000;
        q0.delete();
        q1.delete();
    endtask

    task automatic busy_len(input string tag);
        int n;
        n = 0;
        while (b0.Busy === 1'b1 && n < 40) begin
            idle();
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 16; i++) mm[i] = 16'hxxxx;
        Rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        #12;
        reset_check();
        Rst_n = 1'b1;
        busy_len("busy_after_reset");
        read_all_zero();

        wr(4'd3, 16'hA55A, 2'b11);
        rd(4'd3);
        wr(4'd3, 16'h1234, 2'b01);
        rd(4'd3);
        chk("partial_write", 32'(b0.Dout), 32'h0000A534);
        wr(4'd3, 16'hFFFF, 2'b00);
        rd(4'd3);

        wr(4'd5, 16'h00FF, 2'b11);
        step(1'b0, 1'b1, 2'b10, 4'd5, 16'hBEEF, 1'b1, 4'd5);
        chk("coll_old", 32'(b0.Dout), 32'h000000FF);
        chk("coll_new", 32'(b1.Dout), 32'h0000BEFF);
        rd(4'd5);

        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        step(1'b1, 1'b1, 2'b11, 4'd3, 16'hFFFF, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
        end
        chk("sweep_done", 32'(b0.Busy), 32'h0);
        read_all_zero();

        wr(4'd7, 16'hCAFE, 2'b11);
        rd(4'd7);
        step(1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0);
        end
        #3;
        Rst_n = 1'b0;
        #1;
        reset_check();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        busy_len("busy_after_midreset");
        read_all_zero();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
